// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard / interrupt-entry controller:
// FSM encoding, default register address width and the interrupt vector.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SAVE  = 2'd2,
        ST_JUMP  = 2'd3
    } hz_state_e;

    localparam int          REG_AW_DEF = 3;
    localparam int          DRAIN_W    = 3;
    localparam logic [15:0] INT_VECTOR = 16'h0040;

    // True while an interrupt entry sequence owns the pipeline.
    function automatic logic in_entry(input hz_state_e st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and interrupt-entry sequencing for the
// F/D and D/E buffers and the PC register.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              de_mem_read,
    input  logic              de_reg_write,
    input  logic [REG_AW-1:0] de_write_add,
    input  logic              ex_branch_taken,
    input  logic              int_req,
    output logic              pc_stall,
    output logic              fd_stall,
    output logic              fd_flush,
    output logic              de_flush,
    output logic              int_save,
    output logic              int_ack,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [DRAIN_W-1:0] DRAIN_RELOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    hz_state_e          state_r, next_state_s;
    logic [DRAIN_W-1:0] drain_cnt_r, next_drain_cnt_s;
    logic               int_pending_r, next_pending_s;
    logic               lu_s;
    logic               stall_inc_s;
    logic               pc_stall_s, fd_stall_s, fd_flush_s, de_flush_s;
    logic               int_save_s, int_ack_s;

    assign lu_s = de_mem_read & de_reg_write &
                  ((dec_use_rs1 & (dec_rs1 == de_write_add)) |
                   (dec_use_rs2 & (dec_rs2 == de_write_add)));

    // State, drain counter and pending-interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            drain_cnt_r   <= {DRAIN_W{1'b0}};
            int_pending_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            drain_cnt_r   <= next_drain_cnt_s;
            int_pending_r <= next_pending_s;
        end
    end

    // Next-state and strobe decode; a branch always outranks interrupt and stall.
    always_comb begin
        next_state_s     = state_r;
        next_drain_cnt_s = drain_cnt_r;
        next_pending_s   = int_pending_r;
        stall_inc_s      = 1'b0;
        pc_stall_s       = 1'b0;
        fd_stall_s       = 1'b0;
        fd_flush_s       = 1'b0;
        de_flush_s       = 1'b0;
        int_save_s       = 1'b0;
        int_ack_s        = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    fd_flush_s     = 1'b1;
                    de_flush_s     = 1'b1;
                    next_pending_s = int_pending_r | int_req;
                end else if (int_req || int_pending_r) begin
                    fd_flush_s       = 1'b1;
                    pc_stall_s       = 1'b1;
                    next_state_s     = ST_DRAIN;
                    next_drain_cnt_s = DRAIN_RELOAD;
                    next_pending_s   = 1'b0;
                end else if (lu_s) begin
                    pc_stall_s  = 1'b1;
                    fd_stall_s  = 1'b1;
                    de_flush_s  = 1'b1;
                    stall_inc_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_stall_s = 1'b1;
                fd_flush_s = 1'b1;
                // The branch target becomes the return PC, so draining restarts.
                if (ex_branch_taken) begin
                    de_flush_s       = 1'b1;
                    next_drain_cnt_s = DRAIN_RELOAD;
                end else if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
                    next_state_s = ST_SAVE;
                end else begin
                    next_drain_cnt_s = drain_cnt_r - {{(DRAIN_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SAVE: begin
                int_save_s   = 1'b1;
                pc_stall_s   = 1'b1;
                fd_flush_s   = 1'b1;
                next_state_s = ST_JUMP;
            end
            ST_JUMP: begin
                int_ack_s    = 1'b1;
                fd_flush_s   = 1'b1;
                next_state_s = ST_RUN;
            end
            default: begin
                next_state_s = ST_RUN;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is held.
    assign pc_stall = pc_stall_s & rst_n;
    assign fd_stall = fd_stall_s & rst_n;
    assign fd_flush = fd_flush_s & rst_n;
    assign de_flush = de_flush_s & rst_n;
    assign int_save = int_save_s & rst_n & in_entry(state_r);
    assign int_ack  = int_ack_s  & rst_n & in_entry(state_r);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .clear (1'b0),
        .count (stall_count)
    );

endmodule
